// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared encodings for the pipeline hold / PC redirect controller.
package pipe_hold_ctrl_pkg;

    // Hold levels on the hold_flag bus. A larger value freezes more of the front end.
    typedef enum logic [2:0] {
        HOLD_NONE = 3'd0,
        HOLD_PC   = 3'd1,
        HOLD_IF   = 3'd2,
        HOLD_ID   = 3'd3
    } hold_e;

    // Controller states
    typedef enum logic [1:0] {
        PHC_RUN   = 2'd0,
        PHC_FLUSH = 2'd1,
        PHC_INT   = 2'd2
    } phc_state_e;

    localparam logic [31:0] ZERO_WORD = 32'h0;

endpackage

// File: rtl/pipe_hold_ctrl_gen_pipe_dff.sv
// Generic pipeline register: synchronous reset to def_val, keeps its value while hold_en is set.
module gen_pipe_dff #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold_en,
    input  logic [DW-1:0] def_val,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] qout
);

    logic [DW-1:0] q_d, q_q;

    // Next value: keep while held, otherwise load din
    always_comb begin
        q_d = q_q;
        if (!hold_en) q_d = din;
    end

    // Register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) q_q <= def_val;
        else     q_q <= q_d;
    end

    assign qout = q_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold and PC redirect controller: merges EX jumps, EX/bus stalls and
// CLINT interrupt requests into hold_flag and a single redirect strobe.
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int INT_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_flag_ex_i,
    input  logic        hold_flag_rib_i,
    input  logic        int_req_i,
    input  logic [31:0] int_addr_i,
    output logic [2:0]  hold_flag_o,
    output logic        jump_flag_o,
    output logic [31:0] jump_addr_o,
    output logic        int_ack_o
);

    // The jump cycle itself is one of the FLUSH_CYCLES, so FLUSH only covers the rest.
    localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 1);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 2);
    localparam logic [2:0] INT_RELOAD   = 3'(INT_CYCLES - 1);

    phc_state_e  state_d, state_q;
    logic [2:0]  cnt_d, cnt_q;
    logic [31:0] int_addr_q;
    logic        accept;
    logic        int_fire;

    // Trap vector captured only on the accept cycle
    gen_pipe_dff #(.DW(32)) u_int_addr (
        .clk     (clk),
        .rst     (rst),
        .hold_en (!accept),
        .def_val (ZERO_WORD),
        .din     (int_addr_i),
        .qout    (int_addr_q)
    );

    // Next state / counter; an EX jump overrides everything, including a pending interrupt entry
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        int_fire = 1'b0;
        if (jump_flag_i) begin
            if (FLUSH_MULTI) begin
                state_d = PHC_FLUSH;
                cnt_d   = FLUSH_RELOAD;
            end else begin
                state_d = PHC_RUN;
                cnt_d   = 3'd0;
            end
        end else begin
            case (state_q)
                PHC_RUN: begin
                    if (int_req_i && !hold_flag_ex_i) begin
                        accept  = 1'b1;
                        cnt_d   = INT_RELOAD;
                        state_d = PHC_INT;
                    end
                end
                PHC_FLUSH: begin
                    if (cnt_q == 3'd0) state_d = PHC_RUN;
                    else               cnt_d   = cnt_q - 3'd1;
                end
                PHC_INT: begin
                    // A busy bus freezes the drain so the redirect never lands mid-transfer
                    if (!hold_flag_rib_i) begin
                        if (cnt_q != 3'd0) begin
                            cnt_d = cnt_q - 3'd1;
                        end else begin
                            int_fire = 1'b1;
                            state_d  = PHC_RUN;
                        end
                    end
                end
                default: begin
                    state_d = PHC_RUN;
                    cnt_d   = 3'd0;
                end
            endcase
        end
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= PHC_RUN;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output mux: hold is the max of the active requests; redirect address is zero unless strobed
    always_comb begin
        hold_flag_o = HOLD_NONE;
        jump_flag_o = 1'b0;
        jump_addr_o = ZERO_WORD;
        int_ack_o   = 1'b0;
        if (!rst) begin
            if (hold_flag_rib_i) hold_flag_o = HOLD_PC;
            if (jump_flag_i || hold_flag_ex_i || state_q != PHC_RUN) hold_flag_o = HOLD_ID;
            if (jump_flag_i) begin
                jump_flag_o = 1'b1;
                jump_addr_o = jump_addr_i;
            end else if (int_fire) begin
                jump_flag_o = 1'b1;
                jump_addr_o = int_addr_q;
                int_ack_o   = 1'b1;
            end
        end
    end

endmodule
